// File: rtl/sd_rx_pkg.sv
// Shared types and CRC16 helpers for the SD DAT0 receive path.
// Also intended for the future transmit path.
package sd_rx_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, DATA, CRC, END, DONE} state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'h0000;

  // One serial step of CRC16-CCITT with the feedback bit folded into the polynomial.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic d);
    logic inv;
    inv = d ^ crc[15];
    return {crc[14:0], 1'b0} ^ (inv ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_lfsr.sv
// Serial CRC16 (x^16+x^12+x^5+1) generator.
// Advances one bit per enabled cycle; clr restarts from the initial value.
module sd_crc16_lfsr
  import sd_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (rst)
      crc <= 16'h0000;
    else if (clr)
      crc <= CRC16_INIT;
    else if (en)
      crc <= crc16_step(crc, din);
  end

endmodule

// File: rtl/sd_data_crc_rx.sv
// SD DAT0 single-bit block receiver: start-bit hunt, MSB-first byte deserialiser,
// CRC16 over the data, capture of the trailing CRC and end-bit check.
module sd_data_crc_rx
  import sd_rx_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             dat_in,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [TO_W-1:0]  to_limit,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic             end_ok,
  output logic             timeout,
  output logic [15:0]      crc_calc,
  output logic [15:0]      crc_rx
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt;
  logic [TO_W-1:0]  to_lim_q;
  logic [TO_W-1:0]  to_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       crc_cnt;
  logic [6:0]       shreg;
  logic             lfsr_clr;
  logic             lfsr_en;
  logic [TO_W:0]    to_next;
  logic             to_hit;

  assign lfsr_clr = (state == IDLE) && start && !abort;
  assign lfsr_en  = (state == DATA) && bit_en && !abort;
  assign busy     = (state != IDLE);

  // A zero limit times out on the very first idle-high strobe.
  assign to_next = {1'b0, to_cnt} + (TO_W+1)'(1);
  assign to_hit  = (to_lim_q == '0) || (to_next == {1'b0, to_lim_q});

  sd_crc16_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .clr (lfsr_clr),
    .en  (lfsr_en),
    .din (dat_in),
    .crc (crc_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      byte_cnt   <= '0;
      to_lim_q   <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      crc_cnt    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      done       <= 1'b0;
      crc_ok     <= 1'b0;
      end_ok     <= 1'b0;
      timeout    <= 1'b0;
      crc_rx     <= '0;
    end else begin
      byte_valid <= 1'b0;
      done       <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= WAIT;
              len_q    <= blk_len;
              to_lim_q <= to_limit;
              to_cnt   <= '0;
              byte_cnt <= '0;
              bit_cnt  <= '0;
              crc_cnt  <= '0;
              crc_rx   <= '0;
              crc_ok   <= 1'b0;
              end_ok   <= 1'b0;
              timeout  <= 1'b0;
            end
          end
          WAIT: begin
            if (bit_en) begin
              if (!dat_in) begin
                state <= (len_q == '0) ? CRC : DATA;
              end else if (to_hit) begin
                state   <= DONE;
                timeout <= 1'b1;
                done    <= 1'b1;
              end else begin
                to_cnt <= to_cnt + TO_W'(1);
              end
            end
          end
          DATA: begin
            if (bit_en) begin
              shreg   <= {shreg[5:0], dat_in};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_out   <= {shreg, dat_in};
                byte_valid <= 1'b1;
                if (byte_cnt == len_q - LEN_W'(1))
                  state <= CRC;
                else
                  byte_cnt <= byte_cnt + LEN_W'(1);
              end
            end
          end
          CRC: begin
            if (bit_en) begin
              crc_rx  <= {crc_rx[14:0], dat_in};
              crc_cnt <= crc_cnt + 4'd1;
              if (crc_cnt == 4'd15)
                state <= END;
            end
          end
          END: begin
            if (bit_en) begin
              end_ok <= dat_in;
              crc_ok <= (crc_rx == crc_calc);
              done   <= 1'b1;
              state  <= DONE;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
